apb_slave_bank: RTL and testbench
=================================

APB_SLAVE_BANK -- requirements
Module: apb_slave_bank

Interface
- REQ-001 Parameter REGS_PER_SLV, 8, number of 32-bit registers per slave; the register index is Paddr[4:2].
- REQ-002 Parameter ERR_CNT_W, 8, width of the saturating protocol-error counter.
- REQ-003 clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 reset  input  1  asynchronous, active-high reset.
- REQ-005 Pselx  input  3  one-hot APB slave select from the bridge; bit i selects slave i.
- REQ-006 Penable  input  1  APB enable; high only in the access phase.
- REQ-007 Pwrite  input  1  APB direction; 1 = write, 0 = read.
- REQ-008 Paddr  input  32  APB address; only bits [4:2] are decoded, all other bits are ignored.
- REQ-009 Pwdata  input  32  APB write data.
- REQ-010 Prdata  output  32  registered read data, returned to the bridge.
- REQ-011 prot_err  output  1  one-cycle pulse on each detected APB protocol violation.
- REQ-012 err_cnt  output  ERR_CNT_W  count of violations, saturating at all-ones.
- REQ-013 xfer_cnt  output  16  count of completed APB transfers, wrapping.

Function
- REQ-014 Storage SHALL be 3 slaves x REGS_PER_SLV x 32-bit registers, with all inputs sampled on the rising clk edge.
- REQ-015 Valid select SHALL mean Pselx is exactly one-hot; Pselx of 000 is idle; any multi-hot value is a violation and is treated as no select.
- REQ-016 The FSM SHALL have the states IDLE, SETUP and ACCESS.
- REQ-017 IDLE SHALL transition as follows:
  - valid select with Penable=0 -> SETUP;
  - Penable=1 -> violation, stay in IDLE;
  - otherwise stay in IDLE.
- REQ-018 On entry to SETUP, the block SHALL latch the select, Paddr[4:2] and Pwrite; for a read it SHALL load Prdata with the selected register; for a write Prdata SHALL hold its value.
- REQ-019 SETUP SHALL transition as follows:
  - Penable=1 with the same Pselx, Paddr[4:2] and Pwrite -> ACCESS;
  - any other input -> violation with no write, then SETUP if the inputs form a valid new setup, else IDLE.
- REQ-020 On the SETUP->ACCESS edge, a write SHALL store Pwdata into the latched register, and xfer_cnt SHALL increment for both reads and writes.
- REQ-021 ACCESS SHALL transition as follows:
  - valid select with Penable=0 -> SETUP (back-to-back transfer, no idle cycle);
  - Pselx=000 -> IDLE;
  - Penable=1 -> violation, go to IDLE.
- REQ-022 Read latency SHALL be fixed: Prdata is valid throughout the access cycle and is held until the next read setup; there is no wait state and no PREADY.
- REQ-023 Read-after-write to the same register SHALL return the new data on the next transfer (minimum 2 cycles after the write access edge).
- REQ-024 Each violation SHALL raise prot_err for exactly one cycle and increment err_cnt; err_cnt SHALL hold at 2^ERR_CNT_W-1 and not wrap.
- REQ-025 xfer_cnt SHALL wrap from 0xFFFF to 0x0000.
- REQ-026 A violation SHALL never modify register contents or Prdata.

Reset
- REQ-027 When reset is asserted, the block SHALL immediately apply all of the following, regardless of clk:
  - FSM to IDLE;
  - all registers to 0x00000000;
  - Prdata to 0;
  - prot_err to 0;
  - err_cnt and xfer_cnt to 0.
- REQ-028 Reset asserted mid-transfer SHALL abort the transfer: no write commits, and after deassertion the next valid setup is accepted normally.

Verification
- REQ-029 Write Pselx=010, Paddr=0x8, Pwdata=0xDEADBEEF, then read the same address -> Prdata=0xDEADBEEF in the read access cycle, xfer_cnt=2, err_cnt=0.
- REQ-030 Back-to-back writes to slave 0 indices 0..7 with data 0x100+i, then back-to-back reads -> each read returns 0x100+i, with no idle cycles between transfers.
- REQ-031 Penable=1 in IDLE, Pselx=011, and Paddr changed between setup and access -> three prot_err pulses, err_cnt=3, and all registers unchanged.
- REQ-032 Inject 300 violations -> err_cnt saturates at 255.
- REQ-033 Assert reset between the setup and access of a write of 0x12345678 -> register stays 0x00000000 and Prdata=0; a subsequent read returns 0x00000000.

Source files
------------

// File: rtl/apb_slave_bank.sv
// apb_slave_bank: three APB slaves of REGS_PER_SLV 32-bit registers with protocol checking.
// Counts transfers and protocol violations; a violation never touches storage or Prdata.
module apb_slave_bank #(
   parameter int REGS_PER_SLV = 8,
   parameter int ERR_CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           Pselx,
   input  logic                 Penable,
   input  logic                 Pwrite,
   input  logic [31:0]          Paddr,
   input  logic [31:0]          Pwdata,
   output logic [31:0]          Prdata,
   output logic                 prot_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [15:0]          xfer_cnt
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state, state_nx;
   logic [31:0] regs [3][REGS_PER_SLV];
   logic [2:0]  sel_q, idx_q, idx;
   logic        wr_q, valid, multi, new_setup, match, err, load, commit;
   logic [1:0]  rslv, wslv;
   logic        unused_addr;
   assign unused_addr = ^{Paddr[31:5], Paddr[1:0]};
   assign idx       = Paddr[4:2];
   assign valid     = $onehot(Pselx);
   assign multi     = |Pselx && !valid;
   assign new_setup = valid && !Penable;
   assign match     = Penable && Pselx == sel_q && idx == idx_q && Pwrite == wr_q;
   assign rslv      = Pselx[2] ? 2'd2 : Pselx[1] ? 2'd1 : 2'd0;
   assign wslv      = sel_q[2] ? 2'd2 : sel_q[1] ? 2'd1 : 2'd0;
   // A valid setup always restarts a transfer, even one that follows a violation in SETUP.
   always_comb begin
      commit   = state == SETUP && match;
      load     = new_setup;
      err      = state == SETUP ? !match : (Penable || multi);
      state_nx = commit ? ACCESS : load ? SETUP : IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sel_q    <= '0;
         idx_q    <= '0;
         wr_q     <= 1'b0;
         Prdata   <= '0;
         prot_err <= 1'b0;
         err_cnt  <= '0;
         xfer_cnt <= '0;
         for (int s = 0; s < 3; s++)
            for (int r = 0; r < REGS_PER_SLV; r++)
               regs[s][r] <= '0;
      end else begin
         state    <= state_nx;
         prot_err <= err;
         if (err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
         if (load) begin
            sel_q <= Pselx;
            idx_q <= idx;
            wr_q  <= Pwrite;
            if (!Pwrite) Prdata <= regs[rslv][idx];
         end
         if (commit) begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (wr_q) regs[wslv][idx_q] <= Pwdata;
         end
      end
   end
endmodule

// File: tb/tb_apb_slave_bank.sv
// tb_apb_slave_bank: directed APB scenarios with hand-computed expectations.
module tb_apb_slave_bank;
   logic        clk = 1'b0, reset = 1'b1;
   logic [2:0]  Pselx = '0;
   logic        Penable = 1'b0, Pwrite = 1'b0;
   logic [31:0] Paddr = '0, Pwdata = '0;
   logic [31:0] Prdata;
   logic        prot_err;
   logic [7:0]  err_cnt;
   logic [15:0] xfer_cnt;
   int tests = 0, fails = 0;

   apb_slave_bank dut (
      .clk(clk), .reset(reset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .prot_err(prot_err),
      .err_cnt(err_cnt), .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [2:0] s, input logic e, input logic w, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      Pselx = s; Penable = e; Pwrite = w; Paddr = a; Pwdata = d;
   endtask

   task automatic idle();
      drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic apb_write(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
      drive(s, 1'b0, 1'b1, a, d);
      drive(s, 1'b1, 1'b1, a, d);
   endtask

   task automatic apb_read(input logic [2:0] s, input logic [31:0] a, output logic [31:0] r);
      drive(s, 1'b0, 1'b0, a, 32'h0);
      drive(s, 1'b1, 1'b0, a, 32'h0);
      r = Prdata;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      tests++; if (Prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata got %h exp %h", Prdata, 32'h0); end
      tests++; if (prot_err !== 1'b0) begin fails++; $display("FAIL reset_prot_err got %b exp 0", prot_err); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
      tests++; if (xfer_cnt !== 16'd0) begin fails++; $display("FAIL reset_xfer_cnt got %0d exp 0", xfer_cnt); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] r;
      apb_write(3'b010, 32'h8, 32'hDEADBEEF);
      apb_read(3'b010, 32'h8, r);
      tests++; if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_read got %h exp %h", r, 32'hDEADBEEF); end
      idle();
      tests++; if (xfer_cnt !== 16'd2) begin fails++; $display("FAIL basic_xfer_cnt got %0d exp 2", xfer_cnt); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL basic_err_cnt got %0d exp 0", err_cnt); end
      apb_read(3'b001, 32'h8, r);
      tests++; if (r !== 32'h0) begin fails++; $display("FAIL slave0_isolation got %h exp 0", r); end
      apb_read(3'b100, 32'h8, r);
      tests++; if (r !== 32'h0) begin fails++; $display("FAIL slave2_isolation got %h exp 0", r); end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      for (int i = 0; i < 8; i++) apb_write(3'b001, 32'(i * 4), 32'h100 + 32'(i));
      for (int i = 0; i < 8; i++) begin
         apb_read(3'b001, 32'(i * 4), r);
         tests++; if (r !== 32'h100 + 32'(i)) begin fails++; $display("FAIL b2b_read[%0d] got %h exp %h", i, r, 32'h100 + 32'(i)); end
      end
      apb_read(3'b001, 32'hFFFF_FFE7, r);
      tests++; if (r !== 32'h101) begin fails++; $display("FAIL addr_upper_ignored got %h exp %h", r, 32'h101); end
      idle();
      tests++; if (xfer_cnt !== 16'd21) begin fails++; $display("FAIL b2b_xfer_cnt got %0d exp 21", xfer_cnt); end
      tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL b2b_err_cnt got %0d exp 0", err_cnt); end
   endtask

   task automatic test_violations();
      logic [31:0] r;
      drive(3'b000, 1'b1, 1'b0, 32'h0, 32'h0);
      idle();
      tests++; if (prot_err !== 1'b1) begin fails++; $display("FAIL viol_idle_penable_pulse got %b exp 1", prot_err); end
      idle();
      tests++; if (prot_err !== 1'b0) begin fails++; $display("FAIL viol_pulse_width got %b exp 0", prot_err); end
      drive(3'b011, 1'b0, 1'b0, 32'h0, 32'h0);
      idle();
      tests++; if (prot_err !== 1'b1 || err_cnt !== 8'd2) begin fails++; $display("FAIL viol_multihot got %b/%0d exp 1/2", prot_err, err_cnt); end
      drive(3'b001, 1'b0, 1'b1, 32'h0, 32'hBAD0BAD0);
      drive(3'b001, 1'b1, 1'b1, 32'h4, 32'hBAD0BAD0);
      idle();
      tests++; if (prot_err !== 1'b1 || err_cnt !== 8'd3) begin fails++; $display("FAIL viol_addr_change got %b/%0d exp 1/3", prot_err, err_cnt); end
      tests++; if (Prdata !== 32'h101) begin fails++; $display("FAIL viol_prdata_held got %h exp %h", Prdata, 32'h101); end
      apb_read(3'b001, 32'h0, r);
      tests++; if (r !== 32'h100) begin fails++; $display("FAIL viol_reg0_unchanged got %h exp %h", r, 32'h100); end
      apb_read(3'b001, 32'h4, r);
      tests++; if (r !== 32'h101) begin fails++; $display("FAIL viol_reg1_unchanged got %h exp %h", r, 32'h101); end
      idle();
      tests++; if (xfer_cnt !== 16'd23) begin fails++; $display("FAIL viol_xfer_cnt got %0d exp 23", xfer_cnt); end
   endtask

   task automatic test_saturation();
      repeat (300) drive(3'b000, 1'b1, 1'b0, 32'h0, 32'h0);
      idle();
      tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL err_cnt_saturate got %0d exp 255", err_cnt); end
      tests++; if (prot_err !== 1'b1) begin fails++; $display("FAIL sat_pulse got %b exp 1", prot_err); end
      apb_write(3'b001, 32'h1C, 32'h55);
      drive(3'b001, 1'b1, 1'b1, 32'h1C, 32'h55);
      idle();
      tests++; if (prot_err !== 1'b1 || err_cnt !== 8'd255) begin fails++; $display("FAIL viol_access_penable got %b/%0d exp 1/255", prot_err, err_cnt); end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      drive(3'b100, 1'b0, 1'b1, 32'h10, 32'h12345678);
      @(negedge clk);
      Penable = 1'b1;
      reset = 1'b1;
      #1;
      tests++; if (Prdata !== 32'h0 || xfer_cnt !== 16'd0 || err_cnt !== 8'd0) begin fails++; $display("FAIL async_reset got %h/%0d/%0d exp 0/0/0", Prdata, xfer_cnt, err_cnt); end
      idle();
      reset = 1'b0;
      apb_read(3'b100, 32'h10, r);
      tests++; if (r !== 32'h0) begin fails++; $display("FAIL reset_abort_write got %h exp 0", r); end
      apb_write(3'b100, 32'h10, 32'hA5A5_0001);
      apb_read(3'b100, 32'h10, r);
      tests++; if (r !== 32'hA5A5_0001) begin fails++; $display("FAIL post_reset_rw got %h exp %h", r, 32'hA5A5_0001); end
      idle();
      tests++; if (xfer_cnt !== 16'd3 || err_cnt !== 8'd0) begin fails++; $display("FAIL post_reset_counts got %0d/%0d exp 3/0", xfer_cnt, err_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_violations();
      test_saturation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
